// File: rtl/clk_div_sched.sv
// rtl/clk_div_sched.sv - glitch-free /2../16 clock divider with wrap-aligned rate switching
// Every rate change, start and stop happens on the 15->0 phase wrap, where all divided bits fall together.
module clk_div_sched #(
  parameter logic [1:0] RESET_SEL = 2'd0
) (
  input  logic       clk_200K,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       sel_req,
  input  logic [1:0] sel,
  output logic       clk_out,
  output logic       rise_tick,
  output logic [1:0] cur_sel,
  output logic       busy,
  output logic       sel_ack
);

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    RUN    = 2'd1,
    SWITCH = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic [1:0] pending;
  logic       wrap;
  logic       out_nxt;

  assign cnt_nxt = cnt + 4'd1;
  assign wrap    = (cnt == 4'hf);
  assign out_nxt = (state != OFF) & cnt_nxt[cur_sel];

  always_ff @(posedge clk_200K or negedge rst) begin
    if (!rst) begin
      cnt       <= 4'd0;
      state     <= OFF;
      cur_sel   <= RESET_SEL;
      pending   <= RESET_SEL;
      clk_out   <= 1'b0;
      rise_tick <= 1'b0;
      busy      <= 1'b0;
      sel_ack   <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      clk_out   <= out_nxt;
      rise_tick <= out_nxt & ~clk_out;
      sel_ack   <= 1'b0;
      case (state)
        OFF: begin
          if (sel_req) begin
            cur_sel <= sel;
            sel_ack <= 1'b1;
          end
          if (wrap && clk_en) state <= RUN;
        end
        RUN: begin
          // Stopping wins over switching; a request arriving with the stop is applied directly.
          if (wrap && !clk_en) begin
            state <= OFF;
            if (sel_req) begin
              cur_sel <= sel;
              sel_ack <= 1'b1;
            end
          end else if (sel_req && !busy) begin
            pending <= sel;
            state   <= SWITCH;
            busy    <= 1'b1;
          end
        end
        SWITCH: begin
          if (wrap) begin
            cur_sel <= pending;
            busy    <= 1'b0;
            sel_ack <= 1'b1;
            state   <= clk_en ? RUN : OFF;
          end
        end
        default: state <= OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_sched.sv
// tb/tb_clk_div_sched.sv - directed plus randomized checks of clk_div_sched against a phase model
// The model tracks the wrap phase as an integer and a pending request as -1 when absent.
`timescale 1ns/1ps
module tb_clk_div_sched;

  localparam logic [1:0] RS = 2'd0;

  logic       clk_200K = 1'b0;
  logic       rst      = 1'b1;
  logic       clk_en   = 1'b0;
  logic       sel_req  = 1'b0;
  logic [1:0] sel      = 2'd0;
  logic       clk_out;
  logic       rise_tick;
  logic [1:0] cur_sel;
  logic       busy;
  logic       sel_ack;

  clk_div_sched #(.RESET_SEL(RS)) dut (
    .clk_200K (clk_200K),
    .rst      (rst),
    .clk_en   (clk_en),
    .sel_req  (sel_req),
    .sel      (sel),
    .clk_out  (clk_out),
    .rise_tick(rise_tick),
    .cur_sel  (cur_sel),
    .busy     (busy),
    .sel_ack  (sel_ack)
  );

  always #2500 clk_200K = ~clk_200K;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  int         m_phase;
  bit         m_on;
  logic [1:0] m_cur;
  int         m_pend;
  logic       m_out;
  logic       m_rise;
  logic       m_ack;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_on    = 1'b0;
    m_cur   = RS;
    m_pend  = -1;
    m_out   = 1'b0;
    m_rise  = 1'b0;
    m_ack   = 1'b0;
  endtask

  task automatic check_all();
    chk($sformatf("clk_out@%0d", cyc),   4'(clk_out),   4'(m_out));
    chk($sformatf("rise_tick@%0d", cyc), 4'(rise_tick), 4'(m_rise));
    chk($sformatf("cur_sel@%0d", cyc),   4'(cur_sel),   4'(m_cur));
    chk($sformatf("busy@%0d", cyc),      4'(busy),      4'(m_pend >= 0));
    chk($sformatf("sel_ack@%0d", cyc),   4'(sel_ack),   4'(m_ack));
  endtask

  task automatic step(input logic ce, input logic rq, input logic [1:0] s);
    bit   wrap;
    int   nphase;
    logic nout;
    clk_en  = ce;
    sel_req = rq;
    sel     = s;
    @(posedge clk_200K);
    wrap   = (m_phase == 15);
    nphase = (m_phase + 1) % 16;
    nout   = m_on && (((nphase >> m_cur) % 2) == 1);
    m_rise = nout && !m_out;
    m_out  = nout;
    m_ack  = 1'b0;
    if (!m_on) begin
      if (rq) begin
        m_cur = s;
        m_ack = 1'b1;
      end
      if (wrap && ce) m_on = 1'b1;
    end else if (m_pend >= 0) begin
      if (wrap) begin
        m_cur  = 2'(m_pend);
        m_pend = -1;
        m_ack  = 1'b1;
        if (!ce) m_on = 1'b0;
      end
    end else if (wrap && !ce) begin
      m_on = 1'b0;
      if (rq) begin
        m_cur = s;
        m_ack = 1'b1;
      end
    end else if (rq) begin
      m_pend = int'(s);
    end
    m_phase = nphase;
    cyc++;
    #1;
    check_all();
  endtask

  task automatic idle(input int n, input logic ce);
    for (int i = 0; i < n; i++) step(ce, 1'b0, 2'd0);
  endtask

  initial begin
    logic ce_r;
    model_reset();
    #1 rst = 1'b0;
    #4;
    chk("reset_clk_out", 4'(clk_out), 4'd0);
    chk("reset_rise", 4'(rise_tick), 4'd0);
    chk("reset_cur_sel", 4'(cur_sel), 4'(RS));
    chk("reset_busy", 4'(busy), 4'd0);
    chk("reset_ack", 4'(sel_ack), 4'd0);
    #5 rst = 1'b1;

    // power-up at /2
    idle(40, 1'b1);

    // rate change to /8 mid-count
    idle(3, 1'b1);
    step(1'b1, 1'b1, 2'd2);
    idle(40, 1'b1);

    // collision: /16 then /4 while busy
    step(1'b1, 1'b1, 2'd3);
    idle(3, 1'b1);
    step(1'b1, 1'b1, 2'd1);
    idle(30, 1'b1);
    chk("collision_cur_sel", 4'(cur_sel), 4'd3);

    // switch to /4, then drop clk_en during a high phase
    step(1'b1, 1'b1, 2'd1);
    idle(20, 1'b1);
    for (int i = 0; i < 8 && !m_out; i++) step(1'b1, 1'b0, 2'd0);
    chk("disable_while_high", 4'(clk_out), 4'd1);
    idle(40, 1'b0);
    idle(40, 1'b1);

    // requests while parked
    idle(20, 1'b0);
    step(1'b0, 1'b1, 2'd2);
    idle(2, 1'b0);
    step(1'b0, 1'b1, 2'd1);
    idle(2, 1'b0);
    chk("off_req_cur_sel", 4'(cur_sel), 4'd1);

    // randomized traffic
    ce_r = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) ce_r = ~ce_r;
      step(ce_r, ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)));
    end

    // reset asserted while a switch is pending
    idle(40, 1'b1);
    step(1'b1, 1'b1, 2'd3);
    idle(2, 1'b1);
    chk("pre_reset_busy", 4'(busy), 4'd1);
    #1000 rst = 1'b0;
    #1;
    chk("midsw_clk_out", 4'(clk_out), 4'd0);
    chk("midsw_rise", 4'(rise_tick), 4'd0);
    chk("midsw_cur_sel", 4'(cur_sel), 4'(RS));
    chk("midsw_busy", 4'(busy), 4'd0);
    chk("midsw_ack", 4'(sel_ack), 4'd0);
    #500 rst = 1'b1;
    model_reset();
    idle(40, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clk_div_sched.md
CLK_DIV_SCHED -- requirements
Module: clk_div_sched

Interface
REQ-001 SHALL have parameter RESET_SEL, default 2'd0, meaning the division select applied after reset.
REQ-002 SHALL have port clk_200K, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port clk_en, input, 1 bit: 1 = run the divided output, 0 = park it low.
REQ-005 SHALL have port sel_req, input, 1 bit: rate-change request, sampled every cycle.
REQ-006 SHALL have port sel, input, 2 bits: requested divide, 0=/2 (100K), 1=/4 (50K), 2=/8 (25K), 3=/16 (12.5K).
REQ-007 SHALL have port clk_out, output, 1 bit: registered, glitch-free divided clock.
REQ-008 SHALL have port rise_tick, output, 1 bit: one-cycle pulse coincident with each clk_out low-to-high transition.
REQ-009 SHALL have port cur_sel, output, 2 bits: the divide currently in effect.
REQ-010 SHALL have port busy, output, 1 bit: a rate change is pending; sel_req is ignored while it is 1.
REQ-011 SHALL have port sel_ack, output, 1 bit: one-cycle pulse when a requested rate takes effect.

Function
REQ-012 SHALL hold a free-running 4-bit phase counter cnt that increments every cycle and wraps 15->0.
- The wrap edge is the edge where cnt goes 15->0.
REQ-013 SHALL implement states OFF, RUN and SWITCH.
REQ-014 SHALL, in RUN or SWITCH, drive clk_out as a register loaded with bit cur_sel of (cnt+1).
- Hence clk_out equals cnt[cur_sel] after the edge, with a 50% duty cycle and period 2^(cur_sel+1) cycles.
REQ-015 SHALL load clk_out with 0 in OFF.
REQ-016 SHALL leave OFF for RUN only on a wrap edge while clk_en=1.
- clk_out therefore always restarts at phase 0.
REQ-017 SHALL leave RUN or SWITCH for OFF only on a wrap edge while clk_en=0.
- The final high phase is never truncated, since every divided bit falls at the wrap.
REQ-018 SHALL, in RUN with sel_req=1 and busy=0, latch sel into a pending register, enter SWITCH and assert busy from the next cycle.
REQ-019 SHALL, in SWITCH on the wrap edge:
- load cur_sel from the pending register;
- clear busy;
- pulse sel_ack for exactly the following cycle;
- return to RUN, or to OFF if clk_en=0.
REQ-020 SHALL, in OFF with sel_req=1, load cur_sel from sel on the next edge, pulse sel_ack for the following cycle and never assert busy.
REQ-021 SHALL accept a request whose sel equals cur_sel normally: full SWITCH, wait for wrap, sel_ack, no visible change on clk_out.
REQ-022 SHALL ignore sel_req and sel in SWITCH; the first latched value is the one applied.
REQ-023 SHALL, when sel_req=1 coincides with a RUN wrap edge, enter SWITCH and apply the request at the next wrap (16 cycles later), not at the current one.
REQ-024 SHALL register rise_tick, set for the cycle after every edge on which clk_out is loaded 1 while its current value is 0; it is never set in OFF.
REQ-025 SHALL allow no clk_out pulse, high or low, shorter than half the shorter of the old and new periods across any rate change.
REQ-026 SHALL drive all outputs from registers, with no combinational path from any input to any output.

Reset
REQ-027 SHALL, while rst=0, immediately force:
- cnt=0, state=OFF, cur_sel=RESET_SEL, pending=RESET_SEL;
- clk_out=0, rise_tick=0, busy=0, sel_ack=0.
REQ-028 SHALL, on reset assertion mid-SWITCH, discard the pending request with no sel_ack.
REQ-029 SHALL, after rst releases, count from cnt=0 on the first rising edge; with clk_en=1 held, RUN is entered on the first wrap, 16 edges after release.

Verification
REQ-030 SHALL cover power-up: rst=0 for 10 ns, then rst=1 with clk_en=1, sel=0 and 2500 ns half-period.
- Expect clk_out=0 for the first 16 edges, then a 100K square wave (10 us period).
- Expect rise_tick pulsing every 2 cycles.
REQ-031 SHALL cover a rate change: in RUN at /2, pulse sel_req with sel=2 mid-count.
- Expect busy=1 until the wrap.
- Expect sel_ack one cycle after the wrap, then a 25K clk_out starting low at phase 0, with no runt pulse.
REQ-032 SHALL cover a request collision: issue sel=3 then, while busy, sel=1.
- Expect cur_sel=3 after the wrap and a single sel_ack.
- Expect the second request dropped.
REQ-033 SHALL cover disable and re-enable: drop clk_en mid-high-phase at /4.
- Expect clk_out to finish its period and stay 0 from the wrap onward, with no rise_tick.
- Re-raise clk_en: expect restart exactly at the next wrap.
REQ-034 SHALL cover a request in OFF: with clk_en=0, pulse sel_req sel=1.
- Expect cur_sel=1 and sel_ack on the next two edges, with busy never set.
REQ-035 SHALL cover reset mid-SWITCH: assert rst=0 while busy=1.
- Expect immediate clear of every output and cur_sel=RESET_SEL, with no sel_ack afterward.
